// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host keycode receiver.
// Conditions the raw PS/2 pins, deserialises 11-bit frames and keeps a
// two-byte history {previous byte, newest byte} for the key decoder.
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 130_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        keycode_valid,
  output logic        frame_err,
  output logic        rx_busy
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Input conditioning signals
  logic          clk_meta;
  logic          clk_sync;
  logic          data_meta;
  logic          data_sync;
  logic          clk_filt;
  logic          clk_filt_d;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  // Frame assembly state
  state_t        state;
  state_t        state_n;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_n;
  logic [7:0]    shift_byte;
  logic [7:0]    shift_byte_n;
  logic          par_ok;
  logic          par_ok_n;
  logic [TW-1:0] idle_cnt;
  logic          timeout;

  // Registered output next values
  logic [15:0]   keycode_n;
  logic          keycode_valid_n;
  logic          frame_err_n;

  // Two-flop synchronisers; the PS/2 lines idle high so they reset to 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // Glitch filter: the filtered clock only follows after FILTER_LEN
  // consecutive synced samples disagree with it; any agreeing sample restarts the run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      clk_filt <= clk_sync;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // Delayed copy of the filtered clock used for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  // Inactivity counter: cleared on every edge and while idle, saturates at the limit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state == IDLE) || fall) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TMO_MAX) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  // A stalled frame is abandoned once the limit is reached without a new edge
  assign timeout = (state != IDLE) && !fall && (idle_cnt == TMO_MAX);

  // FSM state and frame registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift_byte    <= '0;
      par_ok        <= 1'b0;
      keycode       <= '0;
      keycode_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_n;
      bit_cnt       <= bit_cnt_n;
      shift_byte    <= shift_byte_n;
      par_ok        <= par_ok_n;
      keycode       <= keycode_n;
      keycode_valid <= keycode_valid_n;
      frame_err     <= frame_err_n;
    end
  end

  // Next-state logic: one step per detected falling edge, plus the timeout escape
  always_comb begin
    state_n         = state;
    bit_cnt_n       = bit_cnt;
    shift_byte_n    = shift_byte;
    par_ok_n        = par_ok;
    keycode_n       = keycode;
    keycode_valid_n = 1'b0;
    frame_err_n     = 1'b0;

    if (timeout) begin
      state_n     = IDLE;
      frame_err_n = 1'b1;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          // A high data bit here is line noise, not a start bit
          if (!data_sync) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          // LSB arrives first, so shift in from the top
          shift_byte_n = {data_sync, shift_byte[7:1]};
          bit_cnt_n    = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = PARITY;
          end
        end
        PARITY: begin
          par_ok_n = ^{shift_byte, data_sync};
          state_n  = STOP;
        end
        STOP: begin
          if (data_sync && par_ok) begin
            keycode_n       = {keycode[7:0], shift_byte};
            keycode_valid_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: directed scenarios followed by
// random frames compared against a byte-history reference model.
`timescale 1ns/1ps
module tb_ps2_keycode_rx;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int HALF           = 20;

  logic        clk;
  logic        rst_n;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] keycode;
  logic        keycode_valid;
  logic        frame_err;
  logic        rx_busy;

  int checks = 0;
  int errors = 0;
  int valid_hi = 0;
  int err_hi = 0;
  int both_hi = 0;

  // Reference model: bytes accepted since the last reset, in arrival order
  logic [7:0] hist[$];

  ps2_keycode_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .keycode(keycode),
    .keycode_valid(keycode_valid),
    .frame_err(frame_err),
    .rx_busy(rx_busy)
  );

  // 100 MHz system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor sampling on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (keycode_valid) valid_hi++;
    if (frame_err) err_hi++;
    if (keycode_valid && frame_err) both_hi++;
  end

  function automatic logic [15:0] model_keycode();
    if (hist.size() == 0) return 16'h0000;
    if (hist.size() == 1) return {8'h00, hist[0]};
    return {hist[hist.size()-2], hist[hist.size()-1]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge so sampling is race-free
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data settles while the clock is high, then a low/high clock period
  task automatic sendBit(input logic b, input bit glitch);
    ps2_data = b;
    waitCycles(HALF / 2);
    ps2_clk = 1'b0;
    waitCycles(HALF);
    ps2_clk = 1'b1;
    if (glitch) begin
      waitCycles(4);
      ps2_clk = 1'b0;
      waitCycles(FILTER_LEN - 1);
      ps2_clk = 1'b1;
      waitCycles(HALF / 2 - 4 - (FILTER_LEN - 1));
    end else begin
      waitCycles(HALF / 2);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                               input bit glitch, input int nbits);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = (($countones(b) % 2) == 0) ^ bad_par;
    bits[10]  = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      sendBit(bits[i], glitch);
    end
  endtask

  // Full frame followed by checks of the history, pulse counts and busy flag
  task automatic runFrame(input string tag, input logic [7:0] b, input bit bad_par,
                          input bit bad_stop, input bit glitch);
    int v0;
    int e0;
    bit good;
    v0 = valid_hi;
    e0 = err_hi;
    good = !bad_par && !bad_stop;
    applyStimulus(b, bad_par, bad_stop, glitch, 11);
    waitCycles(20);
    if (good) hist.push_back(b);
    checkOutput({tag, " keycode"}, 32'(keycode), 32'(model_keycode()));
    checkOutput({tag, " valid pulses"}, 32'(valid_hi - v0), good ? 32'd1 : 32'd0);
    checkOutput({tag, " err pulses"}, 32'(err_hi - e0), good ? 32'd0 : 32'd1);
    checkOutput({tag, " busy"}, 32'(rx_busy), 32'd0);
  endtask

  initial begin
    int v0;
    int e0;
    logic [7:0] rb;
    int kind;

    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    waitCycles(3);
    checkOutput("reset keycode", 32'(keycode), 32'h0);
    checkOutput("reset valid", 32'(keycode_valid), 32'h0);
    checkOutput("reset err", 32'(frame_err), 32'h0);
    checkOutput("reset busy", 32'(rx_busy), 32'h0);
    rst_n = 1'b1;
    waitCycles(5);

    $display("[TB] single frame 0x29");
    runFrame("f29", 8'h29, 0, 0, 0);

    $display("[TB] release sequence F0 29");
    runFrame("fF0", 8'hF0, 0, 0, 0);
    runFrame("f29b", 8'h29, 0, 0, 0);

    $display("[TB] parity and stop errors");
    runFrame("bad parity", 8'h1C, 1, 0, 0);
    runFrame("bad stop", 8'h5A, 0, 1, 0);

    $display("[TB] idle noise edge");
    v0 = valid_hi;
    e0 = err_hi;
    sendBit(1'b1, 0);
    waitCycles(20);
    checkOutput("noise valid", 32'(valid_hi - v0), 32'd0);
    checkOutput("noise err", 32'(err_hi - e0), 32'd0);
    checkOutput("noise busy", 32'(rx_busy), 32'd0);

    $display("[TB] timeout mid-frame");
    v0 = valid_hi;
    e0 = err_hi;
    applyStimulus(8'h23, 0, 0, 0, 5);
    checkOutput("timeout busy before", 32'(rx_busy), 32'd1);
    waitCycles(TIMEOUT_CYCLES + 100);
    checkOutput("timeout err pulses", 32'(err_hi - e0), 32'd1);
    checkOutput("timeout valid pulses", 32'(valid_hi - v0), 32'd0);
    checkOutput("timeout busy", 32'(rx_busy), 32'd0);
    checkOutput("timeout keycode", 32'(keycode), 32'(model_keycode()));
    runFrame("after timeout", 8'h23, 0, 0, 0);

    $display("[TB] glitch rejection");
    runFrame("glitch", 8'h23, 0, 0, 1);

    $display("[TB] reset mid-frame");
    v0 = valid_hi;
    e0 = err_hi;
    applyStimulus(8'h29, 0, 0, 0, 5);
    rst_n = 1'b0;
    waitCycles(1);
    hist.delete();
    checkOutput("midreset keycode", 32'(keycode), 32'h0);
    checkOutput("midreset valid", 32'(keycode_valid), 32'h0);
    checkOutput("midreset err", 32'(frame_err), 32'h0);
    checkOutput("midreset busy", 32'(rx_busy), 32'h0);
    rst_n = 1'b1;
    waitCycles(5);
    checkOutput("midreset no pulses", 32'((valid_hi - v0) + (err_hi - e0)), 32'd0);
    runFrame("post reset", 8'h29, 0, 0, 0);

    $display("[TB] random frames");
    for (int i = 0; i < 20; i++) begin
      rb   = 8'($urandom);
      kind = $urandom_range(0, 5);
      runFrame($sformatf("rand%0d", i), rb, kind == 0, kind == 1, 0);
    end

    checkOutput("never valid and err together", 32'(both_hi), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
